// File: rtl/cell_scan_sequencer.sv
// Scan sequencer for the game-of-life cell-select decoder: walks cell addresses 0..2**ADDR_W-1 per update.
// Optional periodic auto-step trigger is enabled by defining AUTO_STEP_EN.
module cell_scan_sequencer #(
    parameter int unsigned ADDR_W = 6,
`ifdef AUTO_STEP_EN
    parameter int unsigned PERIOD = 1000,
`endif
    parameter int unsigned GEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] addr,
    output logic              ena,
    output logic              busy,
    output logic              done,
    output logic [GEN_W-1:0]  generation
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_d;
    // idx is the next address to present; addr is the one currently on the bus
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_d;
    logic [ADDR_W-1:0] addr_d;
    logic              ena_d;
    logic              busy_d;
    logic              done_d;
    logic [GEN_W-1:0]  gen_d;
    logic              launch;

`ifdef AUTO_STEP_EN
    localparam int unsigned PRE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_d;
    logic             tick;
    logic             pending;
    logic             pending_d;

    assign tick   = (prescaler == PRE_W'(PERIOD - 1));
    assign launch = start | tick | pending;

    // Free-running prescaler; auto requests seen while busy are held in one pending bit
    always_comb begin
        prescaler_d = tick ? '0 : prescaler + PRE_W'(1);
        pending_d   = pending;
        if (state == S_IDLE) begin
            pending_d = 1'b0;
        end else if (tick) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            pending   <= 1'b0;
        end else begin
            prescaler <= prescaler_d;
            pending   <= pending_d;
        end
    end
`else
    assign launch = start;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        idx_d   = idx;
        addr_d  = addr;
        ena_d   = 1'b0;
        done_d  = 1'b0;
        gen_d   = generation;
        case (state)
            S_IDLE: begin
                addr_d = '0;
                idx_d  = '0;
                if (launch) begin
                    state_d = S_SCAN;
                    if (!pause) begin
                        ena_d = 1'b1;
                        idx_d = ADDR_W'(1);
                    end
                end
            end
            S_SCAN: begin
                if (ena && (&addr)) begin
                    state_d = S_DONE;
                    addr_d  = '0;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    gen_d   = generation + GEN_W'(1);
                end else if (!pause) begin
                    addr_d = idx;
                    ena_d  = 1'b1;
                    idx_d  = idx + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            addr       <= '0;
            ena        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            generation <= '0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            addr       <= addr_d;
            ena        <= ena_d;
            busy       <= busy_d;
            done       <= done_d;
            generation <= gen_d;
        end
    end

endmodule

// File: doc/cell_scan_sequencer.md
# cell_scan_sequencer

Upstream driver for the game-of-life cell-select decoder tree. On each update request it walks a binary cell address from 0 to 2**ADDR_W-1, presenting one address per enabled cycle on `addr` with `ena` qualifying it, so the downstream decoder asserts exactly one cell-update strobe per cycle. It then pulses `done` and increments a generation counter. A single feature, a built-in periodic step trigger, is selected at compile time.

## Interface
- ADDR_W, default 6: cell address width; scan length N = 2**ADDR_W (64 cells for 8x8).
- PERIOD, default 1000: cycles between automatic step requests; used only when AUTO_STEP_EN is defined; legal range ≥ N+2.
- GEN_W, default 16: generation counter width.

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one full scan; sampled only in IDLE
- pause  in  1  hold the scan in place while high
- addr  out  ADDR_W  current cell address, drives decoder `in`
- ena  out  1  address valid, drives decoder `ena`
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse after the last address
- generation  out  GEN_W  count of completed scans, wraps modulo 2**GEN_W

## Operation
- All outputs are registered. Reset values: addr=0, ena=0, busy=0, done=0, generation=0, state=IDLE, prescaler=0, pending=0.
- States:
  - IDLE: ena=0, addr=0. Go to SCAN if start=1 (or an auto request is active/pending).
  - SCAN: busy=1. With pause=0: ena=1 and addr presents the current index; addr increments by 1 each cycle. With pause=1: ena=0, addr holds. When addr=N-1 is presented with ena=1, go to DONE next cycle.
  - DONE: ena=0, addr=0, done=1, generation+1, busy=1. Go to IDLE next cycle.
- start asserted in SCAN or DONE is ignored; it is not queued.
- pause has no effect in IDLE or DONE. pause asserted in the same cycle start is accepted does not block entry to SCAN; it only suppresses ena.
- addr never exceeds N-1, and no address is skipped or repeated with ena=1 within one scan.
- generation wraps from 2**GEN_W-1 to 0 without a flag.
- rst asserted mid-scan aborts immediately. The next cycle shows all reset values, with no done pulse and no generation increment.

## Timing
- start=1 sampled at edge k: ena=1, addr=0 at cycle k+1. With no pause, addr=i at cycle k+1+i, and done=1 at cycle k+N+1. busy is high for cycles k+1..k+N+1. IDLE is reached at k+N+2, where a new start is accepted.
- Each pause cycle in SCAN stretches the scan by exactly one cycle.
- Minimum start-to-start spacing is N+2 cycles.

## Configuration
- Macro `AUTO_STEP_EN`.
- Defined:
  - A free-running prescaler counts 0..PERIOD-1 and is unaffected by pause or state. At terminal count it raises a one-cycle internal request, which is ORed with start.
  - A request arriving while busy sets a single pending bit. The pending bit launches a scan on the first IDLE cycle and is then cleared. Further requests while pending is set are dropped.
  - rst clears both the prescaler and pending.
- Undefined: no prescaler or pending logic. Scans start only from the external start input.

## Test plan
- Reset with rst=1 for 2 cycles, then release: all outputs are 0 and remain 0 with start=0 for 10 cycles.
- ADDR_W=2, pulse start for 1 cycle: addr=0,1,2,3 with ena=1 on four consecutive cycles, then done=1 for one cycle, generation=1, busy=0 on the following cycle.
- ADDR_W=2, start then pause=1 for 3 cycles while addr=1: addr holds at 1 with ena=0 during the pause, resumes at 2, and done arrives 3 cycles later than in the unpaused case. Each address is seen exactly once with ena=1.
- Start during SCAN and start asserted together with rst at addr=2: the mid-scan start is ignored. The rst cycle aborts the scan: ena=0, addr=0, generation unchanged, no done pulse.
- GEN_W=2, run 5 scans: generation steps 1,2,3,0,1.
- With AUTO_STEP_EN defined, PERIOD=8, ADDR_W=2: scans start automatically every 8 cycles. An external start 1 cycle before the auto tick causes the tick to become pending; that scan starts at the first IDLE cycle after the current scan, and no third scan is queued.
